fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the register-read/decode stage.
- Generates sequential PCs and issues requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions in a small in-order queue and presents them to decode with valid/ready.
- Extracts the rs1/rs2 select fields that drive the register file read ports.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch into an in-order queue feeding decode.
// Optional `define FETCH_MISALIGN_CHECK_EN adds misalign_o and a FAULT state for unaligned redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(QUEUE_DEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   inst_q [QUEUE_DEPTH];
    logic [31:0]   pc_q   [QUEUE_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic          grant;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          empty;
    logic          redirect_bad;
    logic [31:0]   redirect_target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_bad    = (redirect_pc_i[1:0] != 2'b00);
    assign redirect_target = redirect_pc_i;
`else
    logic unused_pc_bits;
    assign unused_pc_bits  = ^redirect_pc_i[1:0];
    assign redirect_bad    = 1'b0;
    assign redirect_target = {redirect_pc_i[31:2], 2'b00};
`endif

    // Credit counts both buffered words and in-flight requests, so a push can never overflow.
    assign empty       = (count == '0);
    assign imem_req_o  = !reset && (state == RUN) && !redirect_i
                         && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o && imem_gnt_i;
    assign rsp         = imem_rvalid_i && (outstanding != '0);
    assign push        = rsp && !redirect_i && (discard == '0);

    assign inst_valid_o = !empty && !redirect_i;
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_o       = empty ? 32'd0 : inst_q[head];
    assign pc_o         = empty ? 32'd0 : pc_q[head];
    assign rs1_o        = inst_valid_o ? inst_o[19:15] : 5'd0;
    assign rs2_o        = inst_valid_o ? inst_o[24:20] : 5'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[tail] <= imem_rdata_i;
            pc_q[tail]   <= resp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(rsp);
            if (redirect_i) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                discard  <= outstanding - CW'(rsp);
                state    <= redirect_bad ? FAULT : RUN;
`ifdef FETCH_MISALIGN_CHECK_EN
                misalign_o <= redirect_bad;
`endif
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    tail    <= ptr_inc(tail);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    head <= ptr_inc(head);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an epoch-tagged memory model predicts credit, addresses and the decode stream.
module tb_fetch_unit;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(QD)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    mem_req_t    memq[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          epoch = 0;
    int          buffered = 0;
    logic [31:0] model_fetch;
    logic [31:0] model_next_pc;
    bit          model_fault;

    int          gnt_pct;
    int          ready_pct;
    int          rvalid_pct;
    int          lat_max;
    int          redir_pct;
    bit          force_redirect = 1'b0;
    logic [31:0] force_target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0020_8033;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic setKnobs(input int g, input int r, input int rv, input int lat, input int rd);
        gnt_pct    = g;
        ready_pct  = r;
        rvalid_pct = rv;
        lat_max    = lat;
        redir_pct  = rd;
    endtask

    // One clock cycle: drive inputs, compare outputs at the negedge, advance the model at the posedge.
    task automatic applyStimulus();
        bit          do_redirect;
        bit          rsp;
        bit          exp_req;
        bit          exp_valid;
        bit          grant;
        logic [31:0] target;
        logic [31:0] grant_addr;
        logic [31:0] word;
        mem_req_t    front;

        do_redirect = force_redirect || (int'($urandom_range(99)) < redir_pct);
        target      = force_redirect ? force_target : ($urandom & 32'h0000_0FFF);
        force_redirect = 1'b0;
        rsp = (memq.size() > 0) && (memq[0].due <= cycle) && (int'($urandom_range(99)) < rvalid_pct);

        redirect_i    = do_redirect;
        redirect_pc_i = target;
        imem_gnt_i    = (int'($urandom_range(99)) < gnt_pct);
        inst_ready_i  = (int'($urandom_range(99)) < ready_pct);
        imem_rvalid_i = rsp;
        imem_rdata_i  = rsp ? mem_word(memq[0].addr) : $urandom;

        @(negedge clk);
        exp_req   = !model_fault && !do_redirect && ((memq.size() + buffered) < QD);
        exp_valid = (buffered > 0) && !do_redirect;
        checkOutput("imem_req", {31'd0, imem_req_o}, {31'd0, exp_req});
        if (exp_req) checkOutput("imem_addr", imem_addr_o, model_fetch);
        checkOutput("inst_valid", {31'd0, inst_valid_o}, {31'd0, exp_valid});
        if (exp_valid) begin
            word = mem_word(model_next_pc);
            checkOutput("pc", pc_o, model_next_pc);
            checkOutput("inst", inst_o, word);
            checkOutput("rs1", {27'd0, rs1_o}, {27'd0, word[19:15]});
            checkOutput("rs2", {27'd0, rs2_o}, {27'd0, word[24:20]});
        end else begin
            checkOutput("rs1_idle", {27'd0, rs1_o}, 32'd0);
            checkOutput("rs2_idle", {27'd0, rs2_o}, 32'd0);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("misalign", {31'd0, misalign_o}, {31'd0, model_fault});
`endif
        grant      = imem_req_o && imem_gnt_i;
        grant_addr = imem_addr_o;

        @(posedge clk);
        if (rsp) begin
            front = memq.pop_front();
            if (!do_redirect && front.epoch == epoch) buffered++;
        end
        if (exp_valid && inst_ready_i) begin
            buffered--;
            model_next_pc += 32'd4;
        end
        if (grant) begin
            memq.push_back('{grant_addr, epoch, cycle + int'($urandom_range(lat_max, 1))});
            model_fetch += 32'd4;
        end
        if (do_redirect) begin
            epoch++;
            buffered = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
            model_fault   = (target[1:0] != 2'b00);
            model_fetch   = target;
            model_next_pc = target;
`else
            model_fetch   = {target[31:2], 2'b00};
            model_next_pc = {target[31:2], 2'b00};
`endif
        end
        cycle++;
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic redirectTo(input logic [31:0] t);
        force_redirect = 1'b1;
        force_target   = t;
        applyStimulus();
    endtask

    task automatic resetDut();
        reset         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        inst_ready_i  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req", {31'd0, imem_req_o}, 32'd0);
        checkOutput("reset_valid", {31'd0, inst_valid_o}, 32'd0);
        checkOutput("reset_inst", inst_o, 32'd0);
        checkOutput("reset_pc", pc_o, 32'd0);
        checkOutput("reset_rs1", {27'd0, rs1_o}, 32'd0);
        checkOutput("reset_rs2", {27'd0, rs2_o}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("reset_misalign", {31'd0, misalign_o}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        memq.delete();
        epoch++;
        buffered      = 0;
        model_fetch   = 32'h0;
        model_next_pc = 32'h0;
        model_fault   = 1'b0;
    endtask

    initial begin
        setKnobs(100, 100, 100, 1, 0);
        resetDut();

        // streaming with grant every cycle and single-cycle memory latency
        runCycles(20);

        // decode stalls: credit must stop requests at QD, then one pop frees one slot
        setKnobs(100, 0, 100, 1, 0);
        runCycles(6);
        setKnobs(100, 100, 100, 1, 0);
        runCycles(1);
        setKnobs(100, 0, 100, 1, 0);
        runCycles(4);

        // grant withheld: address and request must hold
        setKnobs(0, 100, 100, 1, 0);
        runCycles(3);
        setKnobs(100, 100, 100, 1, 0);
        runCycles(6);

        // two requests in flight, redirect in the same cycle as a response
        redirectTo(32'h0000_0010);
        setKnobs(100, 100, 0, 1, 0);
        runCycles(3);
        setKnobs(100, 100, 100, 1, 0);
        redirectTo(32'h0000_0100);
        runCycles(10);

        // back-to-back redirects with slow memory
        setKnobs(100, 100, 100, 3, 0);
        runCycles(4);
        redirectTo(32'h0000_0040);
        redirectTo(32'h0000_0080);
        runCycles(15);

        // address wrap at the top of memory
        setKnobs(100, 100, 100, 2, 0);
        redirectTo(32'hFFFF_FFF8);
        runCycles(12);

`ifdef FETCH_MISALIGN_CHECK_EN
        redirectTo(32'h0000_0102);
        runCycles(5);
        redirectTo(32'h0000_0200);
        runCycles(10);
`endif

        // randomized traffic, then a mid-run reset and more traffic
        setKnobs(70, 60, 70, 4, 5);
        runCycles(400);
        resetDut();
        setKnobs(80, 50, 80, 3, 8);
        runCycles(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
